// File: rtl/aes_iter_cipher_ctrl.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion; result 10 edges after accept.
// Single block in flight; in_ready low through ROUND/DONE, ciphertext held until out_ready.
module aes_iter_cipher_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_text,
  input  logic [127:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_text,
  output logic             busy,
  output logic [3:0]       round_idx,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  logic [1:0]   state;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [7:0]   rcon;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_next;
  logic [127:0] sb, sr, mc;
  logic [127:0] round_out;

  // Next round key: w0' pulls in the rotated, substituted last word plus rcon.
  always_comb begin
    w0 = rk_reg[127:96];
    w1 = rk_reg[95:64];
    w2 = rk_reg[63:32];
    w3 = rk_reg[31:0];
    n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

  // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[127-8*i -: 8] = SBOX[state_reg[127-8*i -: 8]];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  // The last round skips MixColumns.
  assign round_out = ((round_idx == 4'd10) ? sr : mc) ^ rk_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      state_reg <= '0;
      rk_reg    <= '0;
      rcon      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_text  <= '0;
      busy      <= 1'b0;
      round_idx <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_reg <= in_text ^ in_key;
            rk_reg    <= in_key;
            rcon      <= 8'h01;
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          rcon      <= xtime(rcon);
          if (round_idx == 4'd10) begin
            out_text  <= round_out;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            round_idx <= 4'd0;
            blk_count <= blk_count + CNT_W'(1);
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_cipher_ctrl.sv
// Bench for aes_iter_cipher_ctrl: reference AES-128 built from GF(2^8) arithmetic, known-answer and random blocks.
module tb_aes_iter_cipher_ctrl;

  localparam int CW = 2;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_text;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_text;
  logic          busy;
  logic [3:0]    round_idx;
  logic [CW-1:0] blk_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_cnt  = 0;
  logic [7:0] sbox_t [256];

  aes_iter_cipher_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .busy(busy), .round_idx(round_idx), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_t[b] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [176];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x;
    logic [127:0] a, b;
    a = pt;
    b = key;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[127:120];
      w[i] = b[127:120];
      a = a << 8;
      b = b << 8;
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[x];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    a = '0;
    for (int i = 0; i < 16; i++) a = {a[119:0], s[i]};
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block, waits (bounded) for in_ready, and steps through the accepting edge.
  task automatic accept(input logic [127:0] t, input logic [127:0] k);
    int n;
    in_text  = t;
    in_key   = k;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
    step(); step();
    chk_cnt++;
    if ({in_ready, out_valid, busy, round_idx, blk_count, out_text} !== '0)
      $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b rnd=%0d cnt=%0d txt=%h, required all zero",
               in_ready, out_valid, busy, round_idx, blk_count, out_text);
    else pass_cnt++;
    reset_n = 1'b1;
    step();
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_rdy: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_fips_c1();
    int n;
    logic ok;
    accept(PT1, K1);
    chk_cnt++;
    if (dut.state_reg !== 128'h00102030405060708090a0b0c0d0e0f0)
      $display("FAIL c1_initial_state: got %h, required 00102030405060708090a0b0c0d0e0f0", dut.state_reg);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || round_idx !== 4'd1)
      $display("FAIL c1_after_accept: rdy=%b busy=%b rnd=%0d, required 0 1 1", in_ready, busy, round_idx);
    else pass_cnt++;
    in_text = {$urandom, $urandom, $urandom, $urandom};
    in_key  = {$urandom, $urandom, $urandom, $urandom};
    ok = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (round_idx !== 4'(j + 1) || out_valid !== 1'b0) ok = 1'b0;
    end
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL c1_round_progress: round_idx/out_valid sequence wrong, required 2..10 with out_valid 0");
    else pass_cnt++;
    wait_out(n);
    chk_cnt++;
    if (n != 1) $display("FAIL c1_latency: out_valid after %0d extra edges, required 1 (10 after accept)", n);
    else pass_cnt++;
    chk_cnt++;
    if (out_text !== CT1 || out_text !== aes_ref(PT1, K1))
      $display("FAIL c1_ciphertext: got %h, required %h", out_text, CT1);
    else pass_cnt++;
    chk_cnt++;
    if (round_idx !== 4'd10) $display("FAIL c1_done_round: got %0d, required 10", round_idx);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || round_idx !== 4'd0 || blk_count !== exp_cnt[CW-1:0])
      $display("FAIL c1_handoff: ov=%b rdy=%b busy=%b rnd=%0d cnt=%0d, required 0 1 0 0 %0d",
               out_valid, in_ready, busy, round_idx, blk_count, exp_cnt[CW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    logic ok;
    logic [127:0] held;
    accept(PT2, K2);
    wait_out(n);
    chk_cnt++;
    if (n != 10) $display("FAIL bp_latency: %0d edges after accept, required 10", n);
    else pass_cnt++;
    held = out_text;
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1;
      in_text  = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (out_valid !== 1'b1 || out_text !== held || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL bp_hold_stable: outputs moved while stalled, required stable with in_ready 0");
    else pass_cnt++;
    chk_cnt++;
    if (out_text !== CT2 || out_text !== aes_ref(PT2, K2))
      $display("FAIL bp_ciphertext: got %h, required %h", out_text, CT2);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0 || blk_count !== exp_cnt[CW-1:0] || in_ready !== 1'b1)
      $display("FAIL bp_release: ov=%b cnt=%0d rdy=%b, required 0 %0d 1", out_valid, blk_count, in_ready, exp_cnt[CW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    in_text = PT1; in_key = K1; in_valid = 1'b1;
    step();
    in_text = PT2; in_key = K2;
    wait_out(n);
    chk_cnt++;
    if (n != 10 || out_text !== aes_ref(PT1, K1))
      $display("FAIL b2b_first: latency %0d text %h, required 10 %h", n, out_text, aes_ref(PT1, K1));
    else pass_cnt++;
    step();
    exp_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_count !== exp_cnt[CW-1:0])
      $display("FAIL b2b_handoff: ov=%b rdy=%b cnt=%0d, required 0 1 %0d", out_valid, in_ready, blk_count, exp_cnt[CW-1:0]);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || round_idx !== 4'd1)
      $display("FAIL b2b_second_accept: rdy=%b busy=%b rnd=%0d, required 0 1 1", in_ready, busy, round_idx);
    else pass_cnt++;
    wait_out(n);
    chk_cnt++;
    if (n != 10 || out_text !== CT2)
      $display("FAIL b2b_second: latency %0d text %h, required 10 %h", n, out_text, CT2);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic ok;
    accept(PT1, K1);
    for (int j = 0; j < 4; j++) step();
    reset_n = 1'b0;
    step();
    exp_cnt = 0;
    chk_cnt++;
    if ({in_ready, out_valid, busy, round_idx, blk_count, out_text} !== '0)
      $display("FAIL midreset_outputs: rdy=%b ov=%b busy=%b rnd=%0d cnt=%0d txt=%h, required all zero",
               in_ready, out_valid, busy, round_idx, blk_count, out_text);
    else pass_cnt++;
    reset_n = 1'b1;
    ok = 1'b1;
    for (int j = 0; j < 15; j++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL midreset_no_output: discarded block surfaced, required out_valid 0");
    else pass_cnt++;
    accept(PT1, K1);
    wait_out(n);
    chk_cnt++;
    if (n != 10 || out_text !== CT1)
      $display("FAIL midreset_next_block: latency %0d text %h, required 10 %h", n, out_text, CT1);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_random_wrap();
    int n, gap;
    logic [127:0] pt, key;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    exp_cnt = 0;
    for (int b = 0; b < 5; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) step();
      accept(pt, key);
      wait_out(n);
      chk_cnt++;
      if (n != 10 || out_text !== aes_ref(pt, key))
        $display("FAIL rand_block%0d: latency %0d text %h, required 10 %h", b, n, out_text, aes_ref(pt, key));
      else pass_cnt++;
      gap = $urandom_range(0, 4);
      for (int j = 0; j < gap; j++) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_cnt++;
      chk_cnt++;
      if (blk_count !== exp_cnt[CW-1:0])
        $display("FAIL wrap_count%0d: blk_count=%0d, required %0d", b, blk_count, exp_cnt[CW-1:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
